// File: rtl/ntt_pkg.sv
// -----------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the NTT datapath (modulus q = 3329).
//   Q       : modulus
//   MU      : floor(2^32 / Q), Barrett reciprocal
//   COEF_W  : coefficient width
//   PROD_W  : full product width
//   coef_t  : coefficient type
//   prod_t  : product type
//   cond_sub_q : one conditional subtraction of Q
// -----------------------------------------------------------------------------
package ntt_pkg;

   localparam int COEF_W = 16;
   localparam int PROD_W = 32;

   localparam logic [15:0] Q  = 16'd3329;
   localparam logic [31:0] MU = 32'h0013AFB7;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [PROD_W-1:0] prod_t;

   // Subtract Q once if the value is not yet below Q.
   function automatic coef_t cond_sub_q(input coef_t r);
      coef_t res;
      if (r >= Q) begin
         res = r - Q;
      end else begin
         res = r;
      end
      return res;
   endfunction

endpackage

// File: rtl/mod_mul_pipe_stage.sv
// -----------------------------------------------------------------------------
// mod_mul_pipe_stage
// One elastic pipeline register: payload plus valid bit with a collapsing
// ready chain.
//   clk, rst     : clock, synchronous active-high reset
//   adv_next_i   : downstream stage will advance (or out_ready for the last)
//   adv_o        : this stage loads on the next edge (!valid || adv_next_i)
//   ld_valid_i   : valid of the incoming payload
//   ld_data_i    : incoming payload
//   valid_o      : stage valid bit
//   data_o       : stage payload
// -----------------------------------------------------------------------------
module mod_mul_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adv_next_i,
   output logic         adv_o,
   input  logic         ld_valid_i,
   input  logic [W-1:0] ld_data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         v_q;
   logic [W-1:0] data_q;

   // An empty stage can always take new data, which lets bubbles collapse.
   assign adv_o = !v_q || adv_next_i;

   // Stage register: load on advance, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= 1'b0;
         data_q <= '0;
      end else if (adv_o) begin
         v_q    <= ld_valid_i;
         data_q <= ld_data_i;
      end
   end

   assign valid_o = v_q;
   assign data_o  = data_q;

endmodule

// File: rtl/mod_mul_pipe.sv
// -----------------------------------------------------------------------------
// mod_mul_pipe
// Three-stage pipelined modular multiplier, (a*b) mod 3329, Barrett reduction
// with full correction, valid/ready streaming on both sides.
//   S1: p  = a*b (32 bit)
//   S2: qe = (p*MU) >> 32, carry p
//   S3: r  = p - qe*Q, then up to two subtractions of Q
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake (in_ready is combinational
//                           from out_ready through the stage chain)
//   in_a, in_b            : unsigned 16-bit operands
//   in_tag                : sideband, passed through unchanged
//   out_valid/out_ready   : output handshake
//   out_res               : residue in [0, Q)
//   out_tag               : tag paired with out_res
// Optional (macro MOD_MUL_RANGE_CHECK_EN):
//   out_err               : operand was >= Q for this result
//   err_seen              : sticky out-of-range flag, cleared by rst only
// -----------------------------------------------------------------------------
module mod_mul_pipe
   import ntt_pkg::*;
#(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_res,
   output logic [TAG_W-1:0] out_tag
`ifdef MOD_MUL_RANGE_CHECK_EN
   ,
   output logic             out_err,
   output logic             err_seen
`endif
);

`ifdef MOD_MUL_RANGE_CHECK_EN
   localparam int ERR_W = 1;
`else
   localparam int ERR_W = 0;
`endif

   localparam int S1_W = TAG_W + ERR_W + PROD_W;
   localparam int S2_W = TAG_W + ERR_W + 2 * PROD_W;
   localparam int S3_W = TAG_W + ERR_W + COEF_W;

   logic            adv1_s, adv2_s, adv3_s;
   logic            s1_v_s, s2_v_s, s3_v_s;
   logic [S1_W-1:0] s1_ld_s, s1_data_s;
   logic [S2_W-1:0] s2_ld_s, s2_data_s;
   logic [S3_W-1:0] s3_ld_s, s3_data_s;

   prod_t      p_s;
   prod_t      s1_p_s, s2_p_s, s2_qe_s, qe_s;
   coef_t      r0_s, r1_s, r2_s;
   logic [TAG_W-1:0] s1_tag_s, s2_tag_s;

   // ---------------- S1: exact product ----------------
   assign p_s = prod_t'(in_a) * prod_t'(in_b);

`ifdef MOD_MUL_RANGE_CHECK_EN
   logic in_err_s, s1_err_s, s2_err_s;
   assign in_err_s = (in_a >= Q) || (in_b >= Q);
   assign s1_ld_s  = {in_tag, in_err_s, p_s};
   assign s1_err_s = s1_data_s[PROD_W];
`else
   assign s1_ld_s  = {in_tag, p_s};
`endif
   assign s1_p_s   = s1_data_s[PROD_W-1:0];
   assign s1_tag_s = s1_data_s[S1_W-1 -: TAG_W];

   // ---------------- S2: Barrett quotient estimate ----------------
   // Upper half of the 64-bit product p*MU; may be short of the true
   // quotient by up to 2, which S3 corrects.
   assign qe_s = prod_t'((64'(s1_p_s) * 64'(MU)) >> 7'd32);

`ifdef MOD_MUL_RANGE_CHECK_EN
   assign s2_ld_s  = {s1_tag_s, s1_err_s, qe_s, s1_p_s};
   assign s2_err_s = s2_data_s[2*PROD_W];
`else
   assign s2_ld_s  = {s1_tag_s, qe_s, s1_p_s};
`endif
   assign s2_p_s   = s2_data_s[PROD_W-1:0];
   assign s2_qe_s  = s2_data_s[2*PROD_W-1:PROD_W];
   assign s2_tag_s = s2_data_s[S2_W-1 -: TAG_W];

   // ---------------- S3: remainder and correction ----------------
   // The remainder is below 3Q, so 16 bits hold it exactly.
   assign r0_s = coef_t'(s2_p_s - s2_qe_s * prod_t'(Q));
   assign r1_s = cond_sub_q(r0_s);
   assign r2_s = cond_sub_q(r1_s);

`ifdef MOD_MUL_RANGE_CHECK_EN
   assign s3_ld_s = {s2_tag_s, s2_err_s, r2_s};
`else
   assign s3_ld_s = {s2_tag_s, r2_s};
`endif

   // ---------------- Stage registers and ready chain ----------------
   mod_mul_pipe_stage #(.W(S1_W)) u_s1 (
      .clk(clk), .rst(rst), .adv_next_i(adv2_s), .adv_o(adv1_s),
      .ld_valid_i(in_valid), .ld_data_i(s1_ld_s),
      .valid_o(s1_v_s), .data_o(s1_data_s)
   );

   mod_mul_pipe_stage #(.W(S2_W)) u_s2 (
      .clk(clk), .rst(rst), .adv_next_i(adv3_s), .adv_o(adv2_s),
      .ld_valid_i(s1_v_s), .ld_data_i(s2_ld_s),
      .valid_o(s2_v_s), .data_o(s2_data_s)
   );

   mod_mul_pipe_stage #(.W(S3_W)) u_s3 (
      .clk(clk), .rst(rst), .adv_next_i(out_ready), .adv_o(adv3_s),
      .ld_valid_i(s2_v_s), .ld_data_i(s3_ld_s),
      .valid_o(s3_v_s), .data_o(s3_data_s)
   );

   assign in_ready  = adv1_s;
   assign out_valid = s3_v_s;
   assign out_res   = s3_data_s[COEF_W-1:0];
   assign out_tag   = s3_data_s[S3_W-1 -: TAG_W];

`ifdef MOD_MUL_RANGE_CHECK_EN
   logic err_seen_q;

   assign out_err  = s3_data_s[COEF_W];
   assign err_seen = err_seen_q;

   // Sticky flag, set when an out-of-range result enters the output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_seen_q <= 1'b0;
      end else if (adv3_s && s2_v_s && s2_err_s) begin
         err_seen_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mod_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_mod_mul_pipe
// Table-driven and random stimulus with a queue scoreboard for mod_mul_pipe.
// Expected residues come from the vector table or from an independent
// (a*b)%3329 model; results are popped and compared when they leave the DUT.
// -----------------------------------------------------------------------------
module tb_mod_mul_pipe;

   localparam int NQ = 3329;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = 16'd0;
   logic [15:0] in_b = 16'd0;
   logic [7:0]  in_tag = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_res;
   logic [7:0]  out_tag;
`ifdef MOD_MUL_RANGE_CHECK_EN
   logic        out_err;
   logic        err_seen;
`endif

   mod_mul_pipe #(.TAG_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag)
`ifdef MOD_MUL_RANGE_CHECK_EN
      , .out_err(out_err), .err_seen(err_seen)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  tag;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [7:0]  tag;
      logic        err;
      int          cyc;
   } sb_t;

   vec_t        vecs [11];
   sb_t         sb [$];
   logic [15:0] st_a [4096];
   logic [15:0] st_b [4096];
   logic [7:0]  st_t [4096];
   logic [15:0] st_e [4096];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        lat_chk = 1'b0;
   logic [15:0] exp_res = 16'd0;
   logic        exp_err = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_res = 16'd0;
   logic [7:0]  prev_tag = 8'd0;

   function automatic logic [15:0] ref_mod(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      return 16'(p % NQ);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sampled at the negative edge: scoreboard push/pop and hold checks.
   task automatic mon();
      sb_t e;
      if (rst) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_res", longint'(out_res), longint'(prev_res));
            chk("hold_tag", longint'(out_tag), longint'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", longint'(sb.size()), 1);
            end else begin
               e = sb.pop_front();
               chk("res", longint'(out_res), longint'(e.res));
               chk("tag", longint'(out_tag), longint'(e.tag));
`ifdef MOD_MUL_RANGE_CHECK_EN
               chk("out_err", longint'(out_err), longint'(e.err));
`endif
               if (lat_chk) chk("latency", longint'(cyc - e.cyc), 3);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{res: exp_res, tag: in_tag, err: exp_err, cyc: cyc});
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = out_res;
         prev_tag   = out_tag;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] tag, input logic [15:0] e);
      in_a    = a;
      in_b    = b;
      in_tag  = tag;
      exp_res = e;
      exp_err = (a >= 16'd3329) || (b >= 16'd3329);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic drain(input string name);
      int g;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      g = 0;
      while (sb.size() > 0 && g < 50) begin
         tick();
         g++;
      end
      chk(name, longint'(sb.size()), 0);
   endtask

   // mode 0: out_ready=1, mode 1: 1,0,0,1,0,1 pattern, else random.
   task automatic run_stream(input int n, input int mode);
      int   idx;
      int   guard;
      logic acc;
      logic pat [6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      idx = 0;
      guard = 0;
      while ((idx < n || sb.size() > 0) && guard < 20 * n + 50) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[guard % 6];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (idx < n) begin
            in_valid = 1'b1;
            set_op(st_a[idx], st_b[idx], st_t[idx], st_e[idx]);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         mon();
         @(posedge clk);
         #1;
         cyc++;
         if (acc) idx++;
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_sent", longint'(idx), longint'(n));
      chk("stream_drained", longint'(sb.size()), 0);
   endtask

   task automatic load_vecs(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         st_a[i] = vecs[(first + i) % 11].a;
         st_b[i] = vecs[(first + i) % 11].b;
         st_t[i] = vecs[(first + i) % 11].tag + 8'(i);
         st_e[i] = vecs[(first + i) % 11].exp;
      end
   endtask

   initial begin
      vecs[0]  = '{a: 16'd1234,  b: 16'd2,     tag: 8'h5A, exp: 16'd2468};
      vecs[1]  = '{a: 16'd3328,  b: 16'd3328,  tag: 8'h01, exp: 16'd1};
      vecs[2]  = '{a: 16'd0,     b: 16'd3328,  tag: 8'h02, exp: 16'd0};
      vecs[3]  = '{a: 16'd1,     b: 16'd3328,  tag: 8'h03, exp: 16'd3328};
      vecs[4]  = '{a: 16'd65535, b: 16'd65535, tag: 8'h04, exp: 16'd113};
      vecs[5]  = '{a: 16'd100,   b: 16'd200,   tag: 8'h05, exp: 16'd26};
      vecs[6]  = '{a: 16'd3000,  b: 16'd3000,  tag: 8'h06, exp: 16'd1713};
      vecs[7]  = '{a: 16'd65535, b: 16'd1,     tag: 8'h07, exp: 16'd2284};
      vecs[8]  = '{a: 16'd4096,  b: 16'd4096,  tag: 8'h08, exp: 16'd2385};
      vecs[9]  = '{a: 16'd3329,  b: 16'd1,     tag: 8'h09, exp: 16'd0};
      vecs[10] = '{a: 16'd17,    b: 16'd0,     tag: 8'h0A, exp: 16'd0};

      // Reset state
      do_reset();
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_res", longint'(out_res), 0);
      chk("rst_out_tag", longint'(out_tag), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
`ifdef MOD_MUL_RANGE_CHECK_EN
      chk("rst_err_seen", longint'(err_seen), 0);
`endif

      // Single op, latency 3
      lat_chk = 1'b1;
      st_a[0] = 16'd1234; st_b[0] = 16'd2; st_t[0] = 8'h5A; st_e[0] = 16'd2468;
      run_stream(1, 0);

      // Whole table back to back, one per cycle, latency 3 each
      for (int i = 0; i < 11; i++) begin
         st_a[i] = vecs[i].a;
         st_b[i] = vecs[i].b;
         st_t[i] = vecs[i].tag;
         st_e[i] = vecs[i].exp;
      end
      run_stream(11, 0);
      lat_chk = 1'b0;

      // Backpressure: 10 ops with toggling out_ready
      load_vecs(1, 10);
      run_stream(10, 1);

      // Bubble collapse with out_ready held low
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_op(vecs[5].a, vecs[5].b, 8'hB0, vecs[5].exp);
      #1;
      chk("bubble_rdy_op0", longint'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("bubble_out_valid", longint'(out_valid), 1);
      for (int i = 1; i < 3; i++) begin
         in_valid = 1'b1;
         set_op(vecs[5 + i].a, vecs[5 + i].b, 8'hB0 + 8'(i), vecs[5 + i].exp);
         #1;
         chk("bubble_rdy_fill", longint'(in_ready), 1);
         tick();
      end
      set_op(vecs[8].a, vecs[8].b, 8'hB3, vecs[8].exp);
      #1;
      chk("full_refuse", longint'(in_ready), 0);
      tick();
      tick();
      chk("full_refuse_hold", longint'(in_ready), 0);
      out_ready = 1'b1;
      #1;
      chk("ready_from_out_ready", longint'(in_ready), 1);
      tick();
      drain("bubble_drain");

      // Reset mid-stream
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_op(vecs[i].a, vecs[i].b, 8'hC0 + 8'(i), vecs[i].exp);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mid_out_valid", longint'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_mid_no_stale", longint'(out_valid), 0);
      end
      lat_chk = 1'b1;
      st_a[0] = 16'd3000; st_b[0] = 16'd3000; st_t[0] = 8'hD1; st_e[0] = 16'd1713;
      run_stream(1, 0);
      lat_chk = 1'b0;

`ifdef MOD_MUL_RANGE_CHECK_EN
      // Out-of-range operand flag and sticky bit
      do_reset();
      chk("err_seen_clear", longint'(err_seen), 0);
      st_a[0] = 16'd3329; st_b[0] = 16'd1; st_t[0] = 8'hE1; st_e[0] = 16'd0;
      run_stream(1, 0);
      chk("err_seen_set", longint'(err_seen), 1);
      do_reset();
      chk("err_seen_rst", longint'(err_seen), 0);
`endif

      // Random operands against the reference model, random backpressure
      for (int i = 0; i < 3000; i++) begin
         if (i % 2 == 0) begin
            st_a[i] = 16'($urandom_range(0, NQ - 1));
            st_b[i] = 16'($urandom_range(0, NQ - 1));
         end else begin
            st_a[i] = 16'($urandom_range(0, 65535));
            st_b[i] = 16'($urandom_range(0, 65535));
         end
         st_t[i] = 8'(i);
         st_e[i] = ref_mod(st_a[i], st_b[i]);
      end
      run_stream(3000, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
